voq_dequeue_sched: RTL and testbench
====================================

# voq_dequeue_sched

Egress-side consumer of the virtual output queues (VOQs), one instance per switch egress. It polls NUM_VOQ VOQs round-robin with single-cycle read requests and captures the buffer pointer each VOQ returns. It hands the pointer to the egress transmit engine, waits for the transmit to complete, then returns the pointer to the free-pointer list.

## Interface
Parameters:
- NUM_VOQ, default 4: number of VOQs served; any value ≥ 2, need not be a power of two.
- ADDR_W, default switch_pkg::ADDR_W: width of a packet-buffer pointer.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- sched_en_i  in  1  enables the start of new dequeues; does not abort a dequeue in flight.
- voq_read_req_o  out  NUM_VOQ  one-hot single-cycle read strobe to VOQ i.
- voq_ptr_i  in  NUM_VOQ×ADDR_W  registered pointer output of each VOQ.
- voq_ptr_valid_i  in  NUM_VOQ  registered pointer-valid output of each VOQ; high in the cycle after a read of a non-empty VOQ.
- tx_valid_o  out  1  a pointer is offered to the transmit engine.
- tx_ready_i  in  1  the transmit engine accepts the pointer.
- tx_ptr_o  out  ADDR_W  pointer offered to the transmit engine.
- tx_voq_o  out  $clog2(NUM_VOQ)  source VOQ index of tx_ptr_o.
- tx_done_i  in  1  single-cycle pulse when the packet has been fully read out of the buffer.
- free_valid_o  out  1  a pointer is returned to the free list.
- free_ready_i  in  1  the free list accepts the pointer.
- free_ptr_o  out  ADDR_W  pointer being freed.
- deq_count_o  out  32  count of completed dequeues; see Configuration.

## Operation
The FSM has five states: REQ, WAIT, ISSUE, BUSY, FREE. Its reset state is REQ.

- **REQ**
  - If sched_en_i=1: assert voq_read_req_o[rr_idx] for exactly one cycle, then go to WAIT.
  - Otherwise stay in REQ with voq_read_req_o=0.
- **WAIT**
  - Sample voq_ptr_valid_i[rr_idx].
  - If it is 1: latch ptr_q←voq_ptr_i[rr_idx] and voq_q←rr_idx, then go to ISSUE.
  - If it is 0 (VOQ empty): rr_idx←next(rr_idx), then go to REQ.
- **ISSUE**
  - tx_valid_o=1, tx_ptr_o=ptr_q, tx_voq_o=voq_q.
  - On tx_valid_o&tx_ready_i, go to BUSY.
  - Outputs hold stable while tx_ready_i=0.
- **BUSY**
  - Wait for tx_done_i=1, then go to FREE.
  - tx_done_i is ignored in every other state.
- **FREE**
  - free_valid_o=1, free_ptr_o=ptr_q.
  - On free_ready_i, rr_idx←next(voq_q), increment the dequeue counter, and go to REQ.
- **Round-robin index**
  - next(i) = (i==NUM_VOQ-1) ? 0 : i+1.
  - After every dequeue and every empty probe, rr_idx advances past the VOQ just served or probed.
- **Invariants**
  - At most one bit of voq_read_req_o is set in any cycle.
  - No read request is issued while a pointer is held (states WAIT through FREE). Each VOQ read therefore yields at most one pointer, and no pointer is lost or duplicated.
- **sched_en_i dropped mid-dequeue:** the current pointer still completes ISSUE, BUSY and FREE. The FSM then parks in REQ.
- **Reset (at any state):** the next cycle is REQ, with rr_idx=0 and ptr_q=0. Any pointer in flight is discarded; the free-list owner reinitialises on the same reset.
- **Output reset values:** voq_read_req_o=0, tx_valid_o=0, tx_ptr_o=0, tx_voq_o=0, free_valid_o=0, free_ptr_o=0, deq_count_o=0.

## Timing
- All outputs are decoded from registered state only; none depends combinationally on an input.
- VOQ read latency is one cycle: the read strobe in cycle t is matched by ptr_valid sampled in cycle t+1.
- From the REQ cycle to tx_valid_o high: 2 cycles (REQ, WAIT, then ISSUE in cycle t+2).
- Minimum dequeue loop with tx_ready_i, tx_done_i and free_ready_i all immediate: 5 cycles per packet.
- An empty probe costs 2 cycles (REQ, WAIT).
- Simultaneous tx_ready_i and tx_done_i in ISSUE: only tx_ready_i is acted on; the completion must arrive in BUSY.

## Configuration
- VOQ_SCHED_STATS_EN defined: deq_count_o is a 32-bit counter. It increments on each FREE handshake, wraps from 0xFFFFFFFF to 0, and clears on reset.
- VOQ_SCHED_STATS_EN undefined: the port exists but is tied to 0, and no counter logic is generated.

## Structure
- switch_pkg holds:
  - ADDR_W, VOQ_DEPTH and NUM_VOQ defaults;
  - the enum sched_state_t {REQ, WAIT, ISSUE, BUSY, FREE}.
- One sub-module is natural: voq_rr_ptr, a modulo-NUM_VOQ index register with an advance input and a load-from-index input.

## Test plan
- VOQ 2 holds pointer 0x15, others empty, sched_en_i=1:
  - probes VOQ 0 and 1, then reads VOQ 2;
  - tx_ptr_o=0x15, tx_voq_o=2;
  - after tx_done_i, free_ptr_o=0x15 and deq_count_o=1.
- All four VOQs hold two pointers each, all handshakes immediate: service order is 0,1,2,3,0,1,2,3, at one packet every 5 cycles.
- tx_ready_i held low for 10 cycles in ISSUE: tx_valid_o, tx_ptr_o and tx_voq_o stay stable, and no voq_read_req_o is asserted.
- NUM_VOQ=3, only VOQ 2 non-empty: after serving VOQ 2, rr_idx wraps to 0 and probing continues 0,1,2.
- rst_n low for one cycle while in BUSY: the next cycle is REQ, all outputs are 0, and the following read strobe targets VOQ 0.
- sched_en_i dropped in ISSUE: the dequeue completes through FREE, then voq_read_req_o stays 0 until sched_en_i returns.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch types: buffer pointer width, VOQ defaults
// and the dequeue scheduler state encoding.
package switch_pkg;

    localparam int ADDR_W    = 8;
    localparam int VOQ_DEPTH = 16;
    localparam int NUM_VOQ   = 4;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        ISSUE,
        BUSY,
        FREE
    } sched_state_t;

endpackage

// File: rtl/voq_rr_ptr.sv
// Modulo-NUM_VOQ round-robin index register.
// Ports: clk, rst_n (sync, active-low); advance steps idx to its
// successor; load sets idx to the successor of load_idx; idx is the
// registered index; idx_next is the value idx takes at the next edge.
module voq_rr_ptr
    import switch_pkg::*;
#(
    parameter  int NUM_VOQ = switch_pkg::NUM_VOQ,
    localparam int IW      = $clog2(NUM_VOQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] idx_next
);

    logic [IW-1:0] idx_q;

    function automatic logic [IW-1:0] succ(input logic [IW-1:0] i);
        return (i == IW'(NUM_VOQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        idx_next = idx_q;
        unique case (1'b1)
            load:    idx_next = succ(load_idx);
            advance: idx_next = succ(idx_q);
            default: idx_next = idx_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_next;
    end

    assign idx = idx_q;

endmodule

// File: rtl/voq_dequeue_sched.sv
// Egress VOQ dequeue scheduler: polls VOQs round-robin, hands each
// pointer to the transmit engine, then returns it to the free list.
// Ports: clk, rst_n (sync, active-low), sched_en_i; VOQ side
// voq_read_req_o / voq_ptr_i / voq_ptr_valid_i; transmit side
// tx_valid_o / tx_ready_i / tx_ptr_o / tx_voq_o / tx_done_i; free
// side free_valid_o / free_ready_i / free_ptr_o; deq_count_o.
// Define VOQ_SCHED_STATS_EN to build the deq_count_o counter.
module voq_dequeue_sched
    import switch_pkg::*;
#(
    parameter  int NUM_VOQ = switch_pkg::NUM_VOQ,
    parameter  int ADDR_W  = switch_pkg::ADDR_W,
    localparam int IW      = $clog2(NUM_VOQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sched_en_i,
    output logic [NUM_VOQ-1:0]               voq_read_req_o,
    input  logic [NUM_VOQ-1:0][ADDR_W-1:0]   voq_ptr_i,
    input  logic [NUM_VOQ-1:0]               voq_ptr_valid_i,
    output logic                             tx_valid_o,
    input  logic                             tx_ready_i,
    output logic [ADDR_W-1:0]                tx_ptr_o,
    output logic [IW-1:0]                    tx_voq_o,
    input  logic                             tx_done_i,
    output logic                             free_valid_o,
    input  logic                             free_ready_i,
    output logic [ADDR_W-1:0]                free_ptr_o,
    output logic [31:0]                      deq_count_o
);

    sched_state_t        state;
    logic [NUM_VOQ-1:0]  req_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [IW-1:0]       voq_q;
    logic                tx_valid_q;
    logic                free_valid_q;
    logic [IW-1:0]       rr_idx;
    logic [IW-1:0]       rr_next;
    logic                empty_probe;
    logic                free_hs;

    function automatic logic [NUM_VOQ-1:0] onehot(
        input logic [IW-1:0] i
    );
        logic [NUM_VOQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign empty_probe = (state == WAIT) && !voq_ptr_valid_i[rr_idx];
    assign free_hs     = (state == FREE) && free_ready_i;

    voq_rr_ptr #(
        .NUM_VOQ (NUM_VOQ)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (empty_probe),
        .load     (free_hs),
        .load_idx (voq_q),
        .idx      (rr_idx),
        .idx_next (rr_next)
    );

    // The read strobe is registered: it is set on the edge that enters
    // (or idles in) REQ, so REQ with req_q!=0 is the strobe cycle and
    // REQ with req_q==0 is the parked cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= REQ;
            req_q        <= '0;
            ptr_q        <= '0;
            voq_q        <= '0;
            tx_valid_q   <= 1'b0;
            free_valid_q <= 1'b0;
        end else begin
            req_q <= '0;
            unique case (state)
                REQ: begin
                    if (|req_q)          state <= WAIT;
                    else if (sched_en_i) req_q <= onehot(rr_idx);
                end
                WAIT: begin
                    if (voq_ptr_valid_i[rr_idx]) begin
                        ptr_q      <= voq_ptr_i[rr_idx];
                        voq_q      <= rr_idx;
                        tx_valid_q <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        state <= REQ;
                        if (sched_en_i) req_q <= onehot(rr_next);
                    end
                end
                ISSUE: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_done_i) begin
                        free_valid_q <= 1'b1;
                        state        <= FREE;
                    end
                end
                FREE: begin
                    if (free_ready_i) begin
                        free_valid_q <= 1'b0;
                        state        <= REQ;
                        if (sched_en_i) req_q <= onehot(rr_next);
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    assign voq_read_req_o = req_q;
    assign tx_valid_o     = tx_valid_q;
    assign tx_ptr_o       = ptr_q;
    assign tx_voq_o       = voq_q;
    assign free_valid_o   = free_valid_q;
    assign free_ptr_o     = ptr_q;

`ifdef VOQ_SCHED_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)       cnt_q <= '0;
        else if (free_hs) cnt_q <= cnt_q + 32'd1;
    end

    assign deq_count_o = cnt_q;
`else
    assign deq_count_o = '0;
`endif

endmodule

// File: tb/tb_voq_dequeue_sched.sv
// Self-checking bench for voq_dequeue_sched: directed table,
// corner-case sequences and randomized rounds against a model.
`timescale 1ns/1ps
module tb_voq_dequeue_sched;

    localparam int N  = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic                 sched_en = 1'b0;
    logic [N-1:0]         req;
    logic [N-1:0][AW-1:0] vptr = '0;
    logic [N-1:0]         vvld = '0;
    logic                 tx_valid, tx_ready, tx_done;
    logic [AW-1:0]        tx_ptr, free_ptr;
    logic [1:0]           tx_voq;
    logic                 free_valid, free_ready;
    logic [31:0]          deq_cnt;

    voq_dequeue_sched #(.NUM_VOQ(N), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sched_en_i      (sched_en),
        .voq_read_req_o  (req),
        .voq_ptr_i       (vptr),
        .voq_ptr_valid_i (vvld),
        .tx_valid_o      (tx_valid),
        .tx_ready_i      (tx_ready),
        .tx_ptr_o        (tx_ptr),
        .tx_voq_o        (tx_voq),
        .tx_done_i       (tx_done),
        .free_valid_o    (free_valid),
        .free_ready_i    (free_ready),
        .free_ptr_o      (free_ptr),
        .deq_count_o     (deq_cnt)
    );

    // Second instance with three VOQs for the wrap-around check.
    logic                 en3 = 1'b0;
    logic [2:0]           req3;
    logic [2:0][AW-1:0]   vptr3 = '0;
    logic [2:0]           vvld3 = '0;
    logic                 tv3, fv3;
    logic [AW-1:0]        tp3, fp3;
    logic [1:0]           tvq3;
    logic [31:0]          dc3;

    voq_dequeue_sched #(.NUM_VOQ(3), .ADDR_W(AW)) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .sched_en_i      (en3),
        .voq_read_req_o  (req3),
        .voq_ptr_i       (vptr3),
        .voq_ptr_valid_i (vvld3),
        .tx_valid_o      (tv3),
        .tx_ready_i      (1'b1),
        .tx_ptr_o        (tp3),
        .tx_voq_o        (tvq3),
        .tx_done_i       (1'b1),
        .free_valid_o    (fv3),
        .free_ready_i    (1'b1),
        .free_ptr_o      (fp3),
        .deq_count_o     (dc3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    // VOQ environment: registered one-cycle read response.
    logic [AW-1:0] vq [N][$];
    logic [AW-1:0] vq3 [$];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            vvld[i] <= 1'b0;
            if (req[i] && vq[i].size() > 0) begin
                vvld[i] <= 1'b1;
                vptr[i] <= vq[i].pop_front();
            end
        end
        vvld3 <= '0;
        if (req3[2] && vq3.size() > 0) begin
            vvld3[2] <= 1'b1;
            vptr3[2] <= vq3.pop_front();
        end
    end

    // Reference model: served order is the first non-empty VOQ at or
    // after the round-robin pointer, which then moves past it.
    logic [AW-1:0] mq [N][$];
    int            m_rr = 0;
    int            m_tx = 0;
    int            m_freed = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_last = '0;

    function automatic void load(input int v, input logic [AW-1:0] p);
        vq[v].push_back(p);
        mq[v].push_back(p);
    endfunction

    function automatic int exp_cnt();
`ifdef VOQ_SCHED_STATS_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    bit   rand_mode = 0;
    bit   tx_block = 0;
    bit   done_hold = 0;
    int   pend = 0;
    int   cyc = 0;
    int   inv_err = 0;
    logic pv_hold = 0;
    logic pv_txv = 0;
    logic [AW-1:0] pv_ptr = '0;
    logic [1:0]    pv_voq = '0;
    int   seen_voq[$];
    int   seen_req[$];
    int   req_cyc[$];
    int   tx_cyc[$];
    int   rise_cyc[$];

    // Transmit/free environment plus monitor, one pass per negedge.
    initial begin
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        free_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (pend > 0) begin
                tx_done = (pend == 1) && !done_hold;
                if (!done_hold) pend--;
            end else if (rand_mode) begin
                tx_done = ($urandom_range(7) == 0);
            end
            tx_ready   = tx_block ? 1'b0 :
                         rand_mode ? 1'($urandom_range(1)) : 1'b1;
            free_ready = rand_mode ? 1'($urandom_range(1)) : 1'b1;
            #1;
            if (!rst_n) begin
                pend    = 0;
                m_rr    = 0;
                m_cnt   = 0;
                pv_hold = 0;
                pv_txv  = 0;
            end else begin
                if ($countones(req) > 1) inv_err++;
                if (req != 0 && (tx_valid || free_valid)) inv_err++;
                if (pv_hold && !(tx_valid && tx_ptr == pv_ptr &&
                                 tx_voq == pv_voq)) inv_err++;
                pv_hold = tx_valid && !tx_ready;
                pv_ptr  = tx_ptr;
                pv_voq  = tx_voq;
                if (req != 0) begin
                    seen_req.push_back(oh_idx(8'(req)));
                    req_cyc.push_back(cyc);
                end
                if (tx_valid && !pv_txv) rise_cyc.push_back(cyc);
                pv_txv = tx_valid;
                if (tx_valid && tx_ready) begin
                    int v;
                    int found;
                    logic [AW-1:0] p;
                    v = -1;
                    found = 0;
                    p = '0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && mq[(m_rr + k) % N].size() > 0) begin
                            v = (m_rr + k) % N;
                            found = 1;
                        end
                    end
                    chk("tx_found", found, 1);
                    if (found) begin
                        p = mq[v].pop_front();
                        m_rr = (v + 1) % N;
                        chk("tx_voq", tx_voq, v);
                        chk("tx_ptr", tx_ptr, p);
                    end
                    m_last = p;
                    seen_voq.push_back(int'(tx_voq));
                    tx_cyc.push_back(cyc);
                    pend = rand_mode ? $urandom_range(3) + 1 : 1;
                    m_tx++;
                end
                if (free_valid && free_ready) begin
                    chk("free_ptr", free_ptr, m_last);
                    m_freed++;
                    m_cnt++;
                end
            end
        end
    end

    typedef struct packed {
        logic [N-1:0]         mask;
        logic [N-1:0][AW-1:0] ptr;
        logic [2:0]           n;
        logic [N-1:0][1:0]    order;
    } vec_t;

    vec_t tbl [5];

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        sched_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            vq[i].delete();
            mq[i].delete();
        end
        m_tx    = 0;
        m_freed = 0;
        seen_voq.delete();
        seen_req.delete();
        req_cyc.delete();
        tx_cyc.delete();
        rise_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int total, input int budget,
                             input string name);
        int t;
        t = 0;
        while (m_freed < total && t < budget) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk({name, "_done"}, m_freed, total);
    endtask

    task automatic wait_txv(input int budget, input string name);
        int t;
        t = 0;
        while (!tx_valid && t < budget) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk({name, "_txv"}, tx_valid, 1);
    endtask

    task automatic round(input int budget, input string name);
        int total;
        total = 0;
        for (int i = 0; i < N; i++) total += mq[i].size();
        @(negedge clk);
        sched_en = 1'b1;
        run_until(total, budget, name);
        @(negedge clk);
        sched_en = 1'b0;
        @(negedge clk);
        #2;
        chk({name, "_count"}, deq_cnt, exp_cnt());
    endtask

    initial begin
        int t;
        int bad;
        int s3[$];
        logic [AW-1:0] p3[$];
        logic [AW-1:0] e3[$];

        tbl[0] = '{mask: 4'b0100,
                   ptr: {8'h00, 8'h15, 8'h00, 8'h00},
                   n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[1] = '{mask: 4'b1111,
                   ptr: {8'h13, 8'h12, 8'h11, 8'h10},
                   n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[2] = '{mask: 4'b1001,
                   ptr: {8'h39, 8'h00, 8'h00, 8'h30},
                   n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd0}};
        tbl[3] = '{mask: 4'b1010,
                   ptr: {8'h4b, 8'h00, 8'h41, 8'h00},
                   n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
        tbl[4] = '{mask: 4'b0001,
                   ptr: {8'h00, 8'h00, 8'h00, 8'hff},
                   n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd0}};

        // Reset state.
        do_reset();
        #2;
        chk("rst_req", req, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txptr", tx_ptr, 0);
        chk("rst_txvoq", tx_voq, 0);
        chk("rst_fv", free_valid, 0);
        chk("rst_fptr", free_ptr, 0);
        chk("rst_cnt", deq_cnt, 0);

        // Directed table.
        for (int k = 0; k < 5; k++) begin
            do_reset();
            for (int v = 0; v < N; v++)
                if (tbl[k].mask[v]) load(v, tbl[k].ptr[v]);
            round(200, "tbl");
            chk("tbl_n", seen_voq.size(), int'(tbl[k].n));
            for (int j = 0; j < int'(tbl[k].n) && j < seen_voq.size(); j++)
                chk("tbl_order", seen_voq[j], int'(tbl[k].order[j]));
            if (k == 0) begin
                chk("probe_n", seen_req.size() >= 3, 1);
                for (int j = 0; j < 3 && j < seen_req.size(); j++)
                    chk("probe_order", seen_req[j], j);
                if (seen_req.size() >= 3 && rise_cyc.size() >= 1)
                    chk("req_to_txv", rise_cyc[0] - req_cyc[2], 2);
                else
                    chk("req_to_txv_seen", rise_cyc.size(), 1);
            end
        end

        // Two pointers per VOQ, immediate handshakes: 5-cycle loop.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < N; v++) load(v, 8'(8'h80 + 16 * r + v));
        round(300, "pair");
        chk("pair_n", seen_voq.size(), 8);
        for (int j = 0; j < 8 && j < seen_voq.size(); j++)
            chk("pair_order", seen_voq[j], j % N);
        for (int j = 1; j < 8 && j < tx_cyc.size(); j++)
            chk("pair_gap", tx_cyc[j] - tx_cyc[j-1], 5);

        // tx_ready held low for 10 cycles in ISSUE.
        do_reset();
        load(1, 8'h33);
        tx_block = 1'b1;
        @(negedge clk);
        sched_en = 1'b1;
        wait_txv(30, "hold");
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            #2;
            if (!(tx_valid && tx_ptr == 8'h33 && tx_voq == 2'd1 &&
                  req == 0)) bad++;
        end
        chk("hold_stable", bad, 0);
        tx_block = 1'b0;
        run_until(1, 50, "hold");
        sched_en = 1'b0;

        // sched_en dropped in ISSUE.
        do_reset();
        load(0, 8'h44);
        load(1, 8'h55);
        tx_block = 1'b1;
        @(negedge clk);
        sched_en = 1'b1;
        wait_txv(30, "drop");
        @(negedge clk);
        sched_en = 1'b0;
        tx_block = 1'b0;
        run_until(1, 50, "drop");
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            #2;
            if (req != 0 || tx_valid) bad++;
        end
        chk("drop_park", bad, 0);
        chk("drop_served", m_tx, 1);
        sched_en = 1'b1;
        run_until(2, 50, "resume");
        sched_en = 1'b0;
        chk("resume_voq", seen_voq.size() == 2 ? seen_voq[1] : -1, 1);

        // Reset asserted for one cycle while in BUSY.
        do_reset();
        load(3, 8'h66);
        done_hold = 1'b1;
        @(negedge clk);
        sched_en = 1'b1;
        t = 0;
        while (m_tx < 1 && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("busy_reached", m_tx, 1);
        @(negedge clk);
        rst_n = 1'b0;
        m_tx    = 0;
        m_freed = 0;
        seen_req.delete();
        seen_voq.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        done_hold = 1'b0;
        #2;
        chk("brst_req", req, 0);
        chk("brst_txv", tx_valid, 0);
        chk("brst_txptr", tx_ptr, 0);
        chk("brst_fv", free_valid, 0);
        chk("brst_fptr", free_ptr, 0);
        chk("brst_cnt", deq_cnt, 0);
        load(0, 8'h70);
        run_until(1, 50, "brst");
        sched_en = 1'b0;
        chk("brst_first_req", seen_req.size() > 0 ? seen_req[0] : -1, 0);

        // Three-VOQ instance: only VOQ 2 non-empty, index wraps.
        do_reset();
        vq3.delete();
        vq3.push_back(8'h21);
        vq3.push_back(8'h22);
        e3.delete();
        e3.push_back(8'h21);
        e3.push_back(8'h22);
        @(negedge clk);
        en3 = 1'b1;
        t = 0;
        while (s3.size() < 9 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
            if (req3 != 0) s3.push_back(oh_idx(8'(req3)));
            if (tv3) p3.push_back(tp3);
        end
        en3 = 1'b0;
        chk("n3_strobes", s3.size(), 9);
        for (int j = 0; j < s3.size(); j++)
            chk("n3_order", s3[j], j % 3);
        chk("n3_tx_n", p3.size(), 2);
        for (int j = 0; j < 2 && j < p3.size(); j++)
            chk("n3_ptr", p3[j], e3[j]);

        // Randomized rounds with random handshake timing.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int v = 0; v < N; v++) begin
                int n;
                n = $urandom_range(3);
                for (int j = 0; j < n; j++)
                    load(v, 8'($urandom_range(255)));
            end
            rand_mode = 1'b1;
            round(2000, "rand");
            rand_mode = 1'b0;
        end

        chk("invariants", inv_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
